cabac_neighbour_rw_ctrl: RTL
============================

CABAC_NEIGHBOUR_RW_CTRL -- requirements
Module: cabac_neighbour_rw_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 7, meaning the neighbour-memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 12, meaning the neighbour word width: {mb_type, chroma_mode, cbp}.
REQ-003 The block SHALL have parameter MB_X_TOTAL, default 128, meaning the number of CTU columns.
REQ-004 The block SHALL have port clk  in  1  system clock; all logic is on the rising edge of clk.
REQ-005 The block SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port start_i  in  1  start of processing for one CTU.
REQ-007 The block SHALL have port ctu_x_i  in  ADDR_W  column of the CTU, sampled with start_i.
REQ-008 The block SHALL have port first_row_i  in  1  CTU lies in row 0 (no top neighbour), sampled with start_i.
REQ-009 The block SHALL have ports mem_r_en_o out 1, mem_r_addr_o out ADDR_W and mem_r_data_i in DATA_W, forming the read port of the 2-port neighbour RAM; read data is valid 1 cycle after mem_r_en_o.
REQ-010 The block SHALL have ports mem_w_en_o out 1, mem_w_addr_o out ADDR_W and mem_w_data_o out DATA_W, forming the write port of the neighbour RAM.
REQ-011 The block SHALL have ports nb_valid_o out 1 and nb_ready_i in 1, forming the neighbour-presentation handshake to the CABAC context stage.
REQ-012 The block SHALL have ports nb_top_o out DATA_W and nb_left_o out DATA_W, carrying the top and left neighbour words.
REQ-013 The block SHALL have ports top_avail_o out 1 and left_avail_o out 1, flagging neighbour availability.
REQ-014 The block SHALL have ports upd_valid_i in 1, upd_ready_o out 1 and upd_data_i in DATA_W, carrying the current CTU's word for write-back.
REQ-015 The block SHALL have ports busy_o out 1, done_o out 1 and err_o out 1; done_o and err_o are single-cycle pulses.

Function
REQ-016 The block SHALL implement the FSM states IDLE, RD, WAIT, PRES, UPD and WR.
REQ-017 In IDLE, start_i=1 with ctu_x_i<MB_X_TOTAL SHALL latch ctu_x and first_row and move the FSM to RD, or to PRES if first_row_i=1.
REQ-018 In IDLE, start_i=1 with ctu_x_i>=MB_X_TOTAL SHALL pulse err_o for 1 cycle, and the FSM SHALL remain in IDLE.
REQ-019 start_i SHALL be ignored outside IDLE; busy_o SHALL be high whenever state!=IDLE.
REQ-020 In RD, mem_r_en_o=1 and mem_r_addr_o=latched ctu_x for exactly 1 cycle, and the FSM SHALL then move to WAIT.
REQ-021 In WAIT, the top register SHALL capture mem_r_data_i, and the FSM SHALL then move to PRES; nb_valid_o therefore rises 3 cycles after the start cycle.
REQ-022 In the first-row case, the top register SHALL be loaded with 0, top_avail_o SHALL be 0, and nb_valid_o SHALL rise 1 cycle after the start cycle.
REQ-023 left_avail_o SHALL be 1 iff the latched ctu_x!=0; when left_avail_o=0, nb_left_o SHALL be 0, otherwise nb_left_o SHALL be the left register.
REQ-024 In PRES, nb_valid_o=1 SHALL hold with stable outputs until nb_ready_i=1, after which the FSM SHALL move to UPD.
REQ-025 In UPD, upd_ready_o=1; upd_valid_i outside UPD SHALL be ignored.
REQ-026 In UPD, upd_valid_i&upd_ready_o SHALL capture upd_data_i and move the FSM to WR.
REQ-027 In WR, for 1 cycle: mem_w_en_o=1, mem_w_addr_o=latched ctu_x and mem_w_data_o=captured word; the left register SHALL load the captured word, done_o SHALL pulse, and the FSM SHALL return to IDLE.
REQ-028 Read and write SHALL never be issued in the same cycle; there is no read-modify-write hazard on one address within a CTU.
REQ-029 The left register SHALL persist across CTUs; a CTU with ctu_x=0 SHALL ignore it, as the start of a new row.

Reset
REQ-030 rst=1 SHALL force the FSM to IDLE and clear the top, left and latched registers to 0.
REQ-031 rst=1 SHALL drive all outputs (mem_*_en_o, nb_valid_o, upd_ready_o, busy_o, done_o, err_o, data/addr outputs) to 0.
REQ-032 Reset asserted mid-operation SHALL abort the operation with no memory write issued.

Configuration
REQ-033 With CABAC_NB_CTU_CNT_EN defined, the block SHALL have an extra output ctu_cnt_o[15:0] that increments on each done_o, wraps 0xFFFF->0, and is reset to 0.
REQ-034 Without CABAC_NB_CTU_CNT_EN, the port and the counter SHALL be absent.

Structure
REQ-035 The FSM state encodings, ADDR_W/DATA_W defaults and the field widths of the neighbour word (mb_type 4, chroma_mode 4, cbp 4) SHALL reside in a shared package, cabac_nb_pkg.
REQ-036 The block SHALL have no sub-module; the RAM SHALL be instantiated externally alongside it.

Verification
REQ-037 start, ctu_x=5, first_row=0, RAM[5]=0xABC -> mem_r_en with addr 5 at start+1; nb_valid at start+3 with nb_top=0xABC, top_avail=1.
REQ-038 start, ctu_x=0, first_row=1 -> no mem_r_en; nb_valid at start+1 with nb_top=0, top_avail=0, left_avail=0.
REQ-039 nb_ready held low for 4 cycles -> nb_valid and nb_top stay stable; then upd_data=0x123 accepted -> mem_w_en for 1 cycle with addr=ctu_x and data 0x123, done pulses, and next CTU ctu_x=6 gets nb_left=0x123.
REQ-040 start with ctu_x=0x7F while MB_X_TOTAL=100 -> err pulse, busy stays 0; a start while busy -> ignored.
REQ-041 rst asserted in the UPD state -> IDLE next cycle, no mem_w_en; with CABAC_NB_CTU_CNT_EN defined, ctu_cnt reads 0, then 3 completed CTUs -> 3.

Source files
------------

// File: rtl/cabac_nb_pkg.sv
// Shared definitions for the CABAC neighbour read/write controller:
// FSM state encodings, default address/data widths and the layout of the
// neighbour word {mb_type, chroma_mode, cbp}.
package cabac_nb_pkg;

   // Default widths of the neighbour RAM interface
   localparam int NB_ADDR_W = 7;
   localparam int NB_DATA_W = 12;

   // Field widths inside one neighbour word
   localparam int MB_TYPE_W     = 4;
   localparam int CHROMA_MODE_W = 4;
   localparam int CBP_W         = 4;

   // Controller FSM state encodings
   localparam int         ST_W    = 3;
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_RD   = 3'd1;
   localparam logic [2:0] ST_WAIT = 3'd2;
   localparam logic [2:0] ST_PRES = 3'd3;
   localparam logic [2:0] ST_UPD  = 3'd4;
   localparam logic [2:0] ST_WR   = 3'd5;

   // Structured view of a neighbour word, MSB first
   typedef struct packed {
      logic [MB_TYPE_W-1:0]     mb_type;
      logic [CHROMA_MODE_W-1:0] chroma_mode;
      logic [CBP_W-1:0]         cbp;
   } nb_word_t;

   // Assemble a neighbour word from its fields
   function automatic nb_word_t nb_pack(input logic [MB_TYPE_W-1:0]     mb_type,
                                        input logic [CHROMA_MODE_W-1:0] chroma_mode,
                                        input logic [CBP_W-1:0]         cbp);
      nb_word_t w;
      w.mb_type     = mb_type;
      w.chroma_mode = chroma_mode;
      w.cbp         = cbp;
      return w;
   endfunction

endpackage

// File: rtl/cabac_neighbour_rw_ctrl.sv
// CABAC neighbour read/write controller.
// Per CTU: fetch the top neighbour word from the external 2-port neighbour
// RAM (skipped in row 0), present top/left words to the context stage, take
// the current CTU's word back and write it to the RAM, keeping it as the next
// CTU's left neighbour.
// Optional feature: define CABAC_NB_CTU_CNT_EN to add ctu_cnt_o[15:0], a
// wrapping count of completed CTUs.
module cabac_neighbour_rw_ctrl
   import cabac_nb_pkg::*;
#(
   parameter int ADDR_W     = NB_ADDR_W,
   parameter int DATA_W     = NB_DATA_W,
   parameter int MB_X_TOTAL = 128
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] ctu_x_i,
   input  logic              first_row_i,
   output logic              mem_r_en_o,
   output logic [ADDR_W-1:0] mem_r_addr_o,
   input  logic [DATA_W-1:0] mem_r_data_i,
   output logic              mem_w_en_o,
   output logic [ADDR_W-1:0] mem_w_addr_o,
   output logic [DATA_W-1:0] mem_w_data_o,
   output logic              nb_valid_o,
   input  logic              nb_ready_i,
   output logic [DATA_W-1:0] nb_top_o,
   output logic [DATA_W-1:0] nb_left_o,
   output logic              top_avail_o,
   output logic              left_avail_o,
   input  logic              upd_valid_i,
   output logic              upd_ready_o,
   input  logic [DATA_W-1:0] upd_data_i,
`ifdef CABAC_NB_CTU_CNT_EN
   output logic [15:0]       ctu_cnt_o,
`endif
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);

   // Column limit widened by one bit so MB_X_TOTAL == 2**ADDR_W is representable
   localparam logic [ADDR_W:0] X_LIMIT = (ADDR_W+1)'(MB_X_TOTAL);

   logic [ST_W-1:0]   state_q, state_d;
   logic [ADDR_W-1:0] ctu_x_q, ctu_x_d;
   logic              first_row_q, first_row_d;
   logic [DATA_W-1:0] top_q, top_d;
   logic [DATA_W-1:0] left_q, left_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              err_q, err_d;
   logic              x_in_range;
   logic              run;

   assign x_in_range = ({1'b0, ctu_x_i} < X_LIMIT);
   // Outputs are forced low while reset is held, even before the reset edge
   assign run        = ~rst;

   // Next-state and register-update logic of the CTU sequencing FSM
   always_comb begin
      state_d     = state_q;
      ctu_x_d     = ctu_x_q;
      first_row_d = first_row_q;
      top_d       = top_q;
      left_d      = left_q;
      wdata_d     = wdata_q;
      err_d       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               if (x_in_range) begin
                  ctu_x_d     = ctu_x_i;
                  first_row_d = first_row_i;
                  if (first_row_i) begin
                     // Row 0 has no top neighbour: skip the RAM read entirely
                     top_d   = '0;
                     state_d = ST_PRES;
                  end else begin
                     state_d = ST_RD;
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_RD: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // RAM data arrives one cycle after the read strobe
            top_d   = mem_r_data_i;
            state_d = ST_PRES;
         end
         ST_PRES: begin
            if (nb_ready_i) begin
               state_d = ST_UPD;
            end
         end
         ST_UPD: begin
            if (upd_valid_i) begin
               wdata_d = upd_data_i;
               state_d = ST_WR;
            end
         end
         ST_WR: begin
            // The word just written is the left neighbour of the next column
            left_d  = wdata_q;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         ctu_x_q     <= '0;
         first_row_q <= 1'b0;
         top_q       <= '0;
         left_q      <= '0;
         wdata_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         ctu_x_q     <= ctu_x_d;
         first_row_q <= first_row_d;
         top_q       <= top_d;
         left_q      <= left_d;
         wdata_q     <= wdata_d;
         err_q       <= err_d;
      end
   end

   // Output decode from the current state, gated low during reset
   always_comb begin
      mem_r_en_o   = run && (state_q == ST_RD);
      mem_r_addr_o = mem_r_en_o ? ctu_x_q : '0;
      mem_w_en_o   = run && (state_q == ST_WR);
      mem_w_addr_o = mem_w_en_o ? ctu_x_q : '0;
      mem_w_data_o = mem_w_en_o ? wdata_q : '0;
      nb_valid_o   = run && (state_q == ST_PRES);
      top_avail_o  = nb_valid_o && !first_row_q;
      left_avail_o = nb_valid_o && (ctu_x_q != '0);
      nb_top_o     = nb_valid_o ? top_q : '0;
      nb_left_o    = left_avail_o ? left_q : '0;
      upd_ready_o  = run && (state_q == ST_UPD);
      busy_o       = run && (state_q != ST_IDLE);
      done_o       = run && (state_q == ST_WR);
      err_o        = run && err_q;
   end

`ifdef CABAC_NB_CTU_CNT_EN
   logic [15:0] ctu_cnt_q;

   // Completed-CTU counter, wraps naturally at 16 bits
   always_ff @(posedge clk) begin
      if (rst) begin
         ctu_cnt_q <= '0;
      end else if (state_q == ST_WR) begin
         ctu_cnt_q <= ctu_cnt_q + 16'd1;
      end
   end

   assign ctu_cnt_o = run ? ctu_cnt_q : '0;
`endif

endmodule
